// File: rtl/cocofdc_pkg.sv
// cocofdc_pkg: shared constants for the floppy-controller CPLD bridge.
//   - Bridge register addresses seen from the AVR-side parallel port.
//   - Control-port bit positions.
//   - Bus-master state encoding.
package cocofdc_pkg;

  localparam logic [15:0] REG_DSKREG = 16'h0000;
  localparam logic [15:0] REG_STATUS = 16'h0011;
  localparam logic [15:0] REG_CTRL   = 16'h0100;

  localparam int CTRL_HALT_REL = 0;
  localparam int CTRL_NMI      = 1;

  typedef enum logic [1:0] {
    BM_IDLE   = 2'd0,
    BM_SETUP  = 2'd1,
    BM_STROBE = 2'd2,
    BM_HOLD   = 2'd3
  } bm_state_e;

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for one asynchronous level.
// Ports:
//   i_clk   in  clock of the destination domain
//   i_rst_n in  synchronous active-low reset (output clears to 0)
//   i_d     in  asynchronous input
//   o_q     out synchronized output
module sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/avr_bus_master.sv
// avr_bus_master: initiator for the AVR-side parallel port of the bridge.
// Turns single host commands into SETUP -> STROBE -> HOLD strobe cycles on
// a_sel/a_rw/a_addrbus/a_databus and returns read data.
// Optional feature macro: INTR_AUTOPOLL_EN -- when defined, rising intr
// levels trigger internal reads of REG_DSKREG (intr[0]) and REG_STATUS
// (intr[1]), reported on evt_*. When undefined, intr is ignored and evt_*
// are tied to 0.
// Ports:
//   clock_50, reset_n            clock, synchronous active-low reset
//   cmd_valid/ready/rw/addr/wdata host command handshake
//   rsp_valid, rsp_rdata         completion pulse and read data
//   a_sel, a_rw, a_addrbus       strobe, direction, address to bridge
//   a_databus                    bidirectional data (driven only on writes)
//   intr                         bridge interrupt levels (async)
//   evt_valid/kind/data          autopoll result
module avr_bus_master
  import cocofdc_pkg::*;
#(
  parameter int SETUP_CYCLES   = 2,
  parameter int SEL_LOW_CYCLES = 16,
  parameter int HOLD_CYCLES    = 2
) (
  input  logic        clock_50,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        a_sel,
  output logic        a_rw,
  output logic [15:0] a_addrbus,
  inout  wire  [7:0]  a_databus,
  input  logic [1:0]  intr,
  output logic        evt_valid,
  output logic        evt_kind,
  output logic [7:0]  evt_data
);

  localparam logic [1:0] S_IDLE   = BM_IDLE;
  localparam logic [1:0] S_SETUP  = BM_SETUP;
  localparam logic [1:0] S_STROBE = BM_STROBE;
  localparam logic [1:0] S_HOLD   = BM_HOLD;

  localparam logic [15:0] LD_SETUP = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] LD_SEL   = 16'(SEL_LOW_CYCLES - 1);
  localparam logic [15:0] LD_HOLD  = 16'(HOLD_CYCLES - 1);

  logic [1:0]  r_state;
  logic [15:0] r_cnt;      // per-state down-counter, reloaded on each state entry
  logic        r_sel;
  logic        r_rw;
  logic        r_drv;      // master owns a_databus
  logic        r_is_poll;  // current cycle is an internal autopoll read
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rd;       // raw sample from the final STROBE cycle
  logic [7:0]  r_rdata;
  logic        r_rsp_valid;

  logic        w_idle;
  logic        w_cnt_done;
  logic        w_accept;
  logic        w_poll_launch;
  logic [15:0] w_poll_addr;

  assign w_idle     = (r_state == S_IDLE);
  assign w_cnt_done = (r_cnt == 16'd0);
  // reset_n gates ready so the host sees 0 for the whole reset window
  assign cmd_ready  = reset_n & w_idle & ~w_poll_launch;
  assign w_accept   = cmd_valid & cmd_ready;

  always_ff @(posedge clock_50) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 16'd0;
      r_sel       <= 1'b1;
      r_rw        <= 1'b1;
      r_drv       <= 1'b0;
      r_is_poll   <= 1'b0;
      r_addr      <= 16'd0;
      r_wdata     <= 8'd0;
      r_rd        <= 8'd0;
      r_rdata     <= 8'd0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_poll_launch) begin
            r_state   <= S_SETUP;
            r_cnt     <= LD_SETUP;
            r_rw      <= 1'b1;
            r_drv     <= 1'b0;
            r_addr    <= w_poll_addr;
            r_is_poll <= 1'b1;
          end else if (w_accept) begin
            r_state   <= S_SETUP;
            r_cnt     <= LD_SETUP;
            r_rw      <= cmd_rw;
            r_drv     <= ~cmd_rw;
            r_addr    <= cmd_addr;
            r_wdata   <= cmd_wdata;
            r_is_poll <= 1'b0;
          end
        end
        S_SETUP: begin
          if (w_cnt_done) begin
            r_state <= S_STROBE;
            r_cnt   <= LD_SEL;
            r_sel   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_STROBE: begin
          if (w_cnt_done) begin
            r_state <= S_HOLD;
            r_cnt   <= LD_HOLD;
            r_sel   <= 1'b1;
            if (r_rw) r_rd <= a_databus;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_HOLD: begin
          if (w_cnt_done) begin
            // direction flips back only here, with a_sel already high
            r_state <= S_IDLE;
            r_rw    <= 1'b1;
            r_drv   <= 1'b0;
            if (!r_is_poll) begin
              r_rsp_valid <= 1'b1;
              if (r_rw) r_rdata <= r_rd;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign a_sel     = r_sel;
  assign a_rw      = r_rw;
  assign a_addrbus = r_addr;
  assign a_databus = r_drv ? r_wdata : 8'hzz;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;

`ifdef INTR_AUTOPOLL_EN
  logic [1:0] w_intr_s;
  logic [1:0] r_arm;
  logic       r_kind;
  logic       r_evt_valid;
  logic       r_evt_kind;
  logic [7:0] r_evt_data;
  logic       w_poll0;
  logic       w_poll1;
  logic       w_done;

  for (genvar i = 0; i < 2; i++) begin : g_sync
    sync2 u_sync (
      .i_clk   (clock_50),
      .i_rst_n (reset_n),
      .i_d     (intr[i]),
      .o_q     (w_intr_s[i])
    );
  end

  // intr[0] wins over intr[1]; both win over a pending host command
  assign w_poll0       = w_idle & w_intr_s[0] & r_arm[0];
  assign w_poll1       = w_idle & w_intr_s[1] & r_arm[1] & ~w_poll0;
  assign w_poll_launch = w_poll0 | w_poll1;
  assign w_poll_addr   = w_poll0 ? REG_DSKREG : REG_STATUS;
  assign w_done        = (r_state == S_HOLD) & w_cnt_done;

  always_ff @(posedge clock_50) begin
    if (!reset_n) begin
      r_arm       <= 2'b11;
      r_kind      <= 1'b0;
      r_evt_valid <= 1'b0;
      r_evt_kind  <= 1'b0;
      r_evt_data  <= 8'd0;
    end else begin
      r_evt_valid <= 1'b0;
      // re-arm only once the level has dropped, so one assertion = one poll
      if (!w_intr_s[0])  r_arm[0] <= 1'b1;
      else if (w_poll0)  r_arm[0] <= 1'b0;
      if (!w_intr_s[1])  r_arm[1] <= 1'b1;
      else if (w_poll1)  r_arm[1] <= 1'b0;
      if (w_poll_launch) r_kind <= ~w_poll0;
      if (w_done && r_is_poll) begin
        r_evt_valid <= 1'b1;
        r_evt_kind  <= r_kind;
        r_evt_data  <= r_rd;
      end
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_kind  = r_evt_kind;
  assign evt_data  = r_evt_data;
`else
  logic w_unused_intr;
  assign w_unused_intr = ^intr;
  assign w_poll_launch = 1'b0;
  assign w_poll_addr   = REG_DSKREG;
  assign evt_valid     = 1'b0;
  assign evt_kind      = 1'b0;
  assign evt_data      = 8'd0;
`endif

endmodule
